// File: rtl/cpu_fetch_pkg.sv
// Shared CPU definitions: opcodes, the fetch->decode record and the fetch state encoding.
// Pure declarations, so there is no latency or backpressure here.
package cpu_fetch_pkg;

   localparam int TAG_W = 4;

   localparam logic [6:0] OP_LUI      = 7'b0110111;
   localparam logic [6:0] OP_AUIPC    = 7'b0010111;
   localparam logic [6:0] OP_JAL      = 7'b1101111;
   localparam logic [6:0] OP_JALR     = 7'b1100111;
   localparam logic [6:0] OP_BRANCH   = 7'b1100011;
   localparam logic [6:0] OP_LOAD     = 7'b0000011;
   localparam logic [6:0] OP_STORE    = 7'b0100011;
   localparam logic [6:0] OP_IMM      = 7'b0010011;
   localparam logic [6:0] OP_OP       = 7'b0110011;
   localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
   localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OP_FMADD    = 7'b1000011;
   localparam logic [6:0] OP_FMSUB    = 7'b1000111;
   localparam logic [6:0] OP_FNMSUB   = 7'b1001011;
   localparam logic [6:0] OP_FNMADD   = 7'b1001111;

   typedef struct packed {
      logic [31:0]      pc;
      logic [31:0]      instruction;
      logic [4:0]       inst_rs1;
      logic [4:0]       inst_rs2;
      logic [4:0]       inst_rs3;
      logic [4:0]       inst_rd;
      logic [TAG_W-1:0] tag;
   } fetch_data_t;

   typedef enum logic [1:0] {
      ST_FETCH   = 2'd0,
      ST_HOLD    = 2'd1,
      ST_WAIT_PC = 2'd2,
      ST_FAULT   = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/cpu_fetch_fields.sv
// Opcode-driven register-field masking plus control-flow detect.
// Purely combinational, zero latency, no backpressure.
module cpu_fetch_fields
   import cpu_fetch_pkg::*;
(
   input  logic [31:0] instruction,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [4:0]  rs3,
   output logic [4:0]  rd,
   output logic        is_control
);

   logic keep_rs1;
   logic keep_rs2;
   logic keep_rs3;
   logic keep_rd;
   logic unused_funct3;

   assign unused_funct3 = ^instruction[14:12];

   // Keep flags per format: R, I, S, B, U, J, R4, CSR; unknown opcodes keep nothing.
   always_comb begin
      {keep_rs1, keep_rs2, keep_rs3, keep_rd} = 4'b0000;
      is_control = 1'b0;
      case (instruction[6:0])
         OP_OP:                                {keep_rs1, keep_rs2, keep_rs3, keep_rd} = 4'b1101;
         OP_IMM, OP_LOAD:                      {keep_rs1, keep_rs2, keep_rs3, keep_rd} = 4'b1001;
         OP_JALR, OP_MISC_MEM: begin
            {keep_rs1, keep_rs2, keep_rs3, keep_rd} = 4'b1001;
            is_control = 1'b1;
         end
         OP_STORE:                             {keep_rs1, keep_rs2, keep_rs3, keep_rd} = 4'b1100;
         OP_BRANCH: begin
            {keep_rs1, keep_rs2, keep_rs3, keep_rd} = 4'b1100;
            is_control = 1'b1;
         end
         OP_LUI, OP_AUIPC:                     {keep_rs1, keep_rs2, keep_rs3, keep_rd} = 4'b0001;
         OP_JAL: begin
            {keep_rs1, keep_rs2, keep_rs3, keep_rd} = 4'b0001;
            is_control = 1'b1;
         end
         OP_FMADD, OP_FMSUB, OP_FNMSUB, OP_FNMADD:
                                               {keep_rs1, keep_rs2, keep_rs3, keep_rd} = 4'b1111;
         OP_SYSTEM: begin
            {keep_rs1, keep_rs2, keep_rs3, keep_rd} = 4'b1001;
            is_control = 1'b1;
         end
         default: ;
      endcase
   end

   assign rs1 = keep_rs1 ? instruction[19:15] : 5'd0;
   assign rs2 = keep_rs2 ? instruction[24:20] : 5'd0;
   assign rs3 = keep_rs3 ? instruction[31:27] : 5'd0;
   assign rd  = keep_rd  ? instruction[11:7]  : 5'd0;

endmodule

// File: rtl/cpu_fetch.sv
// Instruction fetch: one instruction per bus beat, published on the beat edge.
// i_busy parks the returned word in a hold register; control-flow halts until execute redirects.
module cpu_fetch
   import cpu_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int          TAG_WIDTH    = TAG_W
) (
   input  logic        i_clock,
   input  logic        i_reset_n,
   output logic        o_bus_request,
   output logic [31:0] o_bus_address,
   input  logic        i_bus_ready,
   input  logic [31:0] i_bus_rdata,
   input  logic        i_busy,
   input  logic        i_pc_valid,
   input  logic [31:0] i_pc,
   output fetch_data_t o_data,
   output logic        o_fault
);

   fetch_state_t state;
   fetch_state_t next_state;
   logic [31:0]  pc;
   logic [31:0]  hold_word;
   logic [31:0]  word;
   logic         armed;
   logic         publish;
   logic         capture;
   logic [4:0]   rs1;
   logic [4:0]   rs2;
   logic [4:0]   rs3;
   logic [4:0]   rd;
   logic         is_control;

   assign word = (state == ST_HOLD) ? hold_word : i_bus_rdata;

   cpu_fetch_fields u_fields (
      .instruction (word),
      .rs1         (rs1),
      .rs2         (rs2),
      .rs3         (rs3),
      .rd          (rd),
      .is_control  (is_control)
   );

   // armed keeps the request low for the first cycle out of reset.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state <= ST_FETCH;
         armed <= 1'b0;
      end else begin
         state <= next_state;
         armed <= 1'b1;
      end
   end

   always_comb begin
      next_state = state;
      publish    = 1'b0;
      capture    = 1'b0;
      case (state)
         ST_FETCH: begin
            if (pc[1:0] != 2'b00) begin
               next_state = ST_FAULT;
            end else if (armed && i_bus_ready) begin
               if (i_busy) begin
                  capture    = 1'b1;
                  next_state = ST_HOLD;
               end else begin
                  publish = 1'b1;
                  if (is_control) next_state = ST_WAIT_PC;
               end
            end
         end
         ST_HOLD: begin
            if (!i_busy) begin
               publish    = 1'b1;
               next_state = is_control ? ST_WAIT_PC : ST_FETCH;
            end
         end
         ST_WAIT_PC: begin
            if (i_pc_valid) next_state = ST_FETCH;
         end
         ST_FAULT: ;
         default: next_state = ST_FAULT;
      endcase
   end

   always_comb begin
      o_bus_request = (state == ST_FETCH) && armed && (pc[1:0] == 2'b00);
      o_bus_address = pc;
      o_fault       = (state == ST_FAULT);
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         pc        <= RESET_VECTOR;
         hold_word <= 32'd0;
         o_data    <= '0;
      end else begin
         if (capture) hold_word <= i_bus_rdata;
         if (publish) begin
            o_data.pc          <= pc;
            o_data.instruction <= word;
            o_data.inst_rs1    <= rs1;
            o_data.inst_rs2    <= rs2;
            o_data.inst_rs3    <= rs3;
            o_data.inst_rd     <= rd;
            o_data.tag         <= o_data.tag + TAG_WIDTH'(1);
            if (!is_control) pc <= pc + 32'd4;
         end else if (state == ST_WAIT_PC && i_pc_valid) begin
            pc <= i_pc;
         end
      end
   end

endmodule
